// File: rtl/acc_group_sched.sv
// -----------------------------------------------------------------------------
// acc_group_sched
// Sequences one spectrum accumulation group: arms capture for pulse_num
// pulses, waits out the accumulator write pipeline, streams the spectrum
// buffer out through port B, and then reports completion.
//
// Ports
//   clk_i            system clock (rising edge)
//   rst_i            synchronous active-high reset
//   start_i          one-cycle request to begin a group (honoured in IDLE only)
//   abort_i          one-cycle request to abandon the current group
//   pulse_num_i      pulses per group, latched at start (0 means 1)
//   rangebin_num_i   range bins per pulse, latched at start (0->1, >16->16)
//   spec_acc_done_i  one-cycle pulse: one pulse fully written to the buffer
//   capture_en_o     trigger capture / FFT path enable (ACCUM)
//   spec_acc_ctrl_o  0 = overwrite on the first pulse, 1 = read-add-write
//   pulse_counts_o   pulses completed in the current group (saturating)
//   rd_addr_o        buffer port-B read address during readout
//   rd_sel_o         1 = this block owns buffer port B (READOUT)
//   data_valid_o     port-B read data is valid this cycle
//   group_done_o     one-cycle pulse after the last readout word
//   busy_o           high whenever the block is not IDLE
//
// Every output is a register or a decode of registered state only, so there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module acc_group_sched #(
    parameter int ADDR_W = 14,
    parameter int BIN_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [15:0]       pulse_num_i,
    input  logic [4:0]        rangebin_num_i,
    input  logic              spec_acc_done_i,
    output logic              capture_en_o,
    output logic              spec_acc_ctrl_o,
    output logic [15:0]       pulse_counts_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_sel_o,
    output logic              data_valid_o,
    output logic              group_done_o,
    output logic              busy_o
);

    // One extra bit so that a full 16 x 1024 readout (16384) fits.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_READOUT,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       pulse_num_reg;
    logic [4:0]        rangebin_num_reg;
    logic [15:0]       pulse_cnt_reg;
    logic [1:0]        drain_cnt_reg;
    logic [CNT_W-1:0]  rd_cnt_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              data_valid_reg;

    logic [CNT_W-1:0]  total_words;
    logic              issue;
    logic              last_issue;
    logic              start_ok;
    logic              acc_event;
    logic [16:0]       pulse_inc;
    logic [15:0]       pulse_cnt_sat;
    logic [15:0]       pulse_num_eff;
    logic [4:0]        rangebin_num_eff;

    // Sanitised configuration captured at start.
    always_comb begin
        pulse_num_eff = (pulse_num_i == 16'd0) ? 16'd1 : pulse_num_i;
        if (rangebin_num_i == 5'd0) begin
            rangebin_num_eff = 5'd1;
        end else if (rangebin_num_i > 5'd16) begin
            rangebin_num_eff = 5'd16;
        end else begin
            rangebin_num_eff = rangebin_num_i;
        end
    end

    always_comb begin
        total_words   = CNT_W'(rangebin_num_reg) << BIN_W;
        // A read is issued on every READOUT cycle until all words are out;
        // the one READOUT cycle after that waits for the final RAM word.
        issue         = (state_reg == S_READOUT) && (rd_cnt_reg != total_words);
        last_issue    = (rd_cnt_reg == total_words - CNT_W'(1));
        start_ok      = (state_reg == S_IDLE) && start_i && !abort_i;
        acc_event     = (state_reg == S_ACCUM) && spec_acc_done_i && !abort_i;
        pulse_inc     = {1'b0, pulse_cnt_reg} + 17'd1;
        pulse_cnt_sat = (pulse_cnt_reg == 16'hFFFF) ? pulse_cnt_reg : pulse_inc[15:0];
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (acc_event && (pulse_inc == {1'b0, pulse_num_reg})) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (drain_cnt_reg == 2'd3) begin
                    state_next = S_READOUT;
                end
            end
            S_READOUT: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (!issue) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pulse_num_reg    <= '0;
            rangebin_num_reg <= '0;
            pulse_cnt_reg    <= '0;
            drain_cnt_reg    <= '0;
            rd_cnt_reg       <= '0;
            rd_addr_reg      <= '0;
            data_valid_reg   <= 1'b0;
        end else begin
            if (start_ok) begin
                pulse_num_reg    <= pulse_num_eff;
                rangebin_num_reg <= rangebin_num_eff;
                pulse_cnt_reg    <= '0;
            end else if (acc_event) begin
                pulse_cnt_reg <= pulse_cnt_sat;
            end

            if (state_reg == S_DRAIN) begin
                drain_cnt_reg <= drain_cnt_reg + 2'd1;
            end else begin
                drain_cnt_reg <= '0;
            end

            if (state_reg == S_READOUT) begin
                if (issue) begin
                    rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
                    // The address parks on the final word rather than
                    // stepping past the end of the buffer.
                    if (!last_issue) begin
                        rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
                    end
                end
            end else begin
                rd_cnt_reg  <= '0;
                rd_addr_reg <= '0;
            end

            // RAM read latency is one cycle; an abort squashes the word in flight.
            data_valid_reg <= issue && !abort_i;
        end
    end

    always_comb begin
        capture_en_o    = (state_reg == S_ACCUM);
        spec_acc_ctrl_o = (state_reg == S_ACCUM) && (pulse_cnt_reg != 16'd0);
        pulse_counts_o  = pulse_cnt_reg;
        rd_addr_o       = rd_addr_reg;
        rd_sel_o        = (state_reg == S_READOUT);
        data_valid_o    = data_valid_reg;
        group_done_o    = (state_reg == S_DONE);
        busy_o          = (state_reg != S_IDLE);
    end

endmodule

// File: tb/tb_acc_group_sched.sv
// -----------------------------------------------------------------------------
// tb_acc_group_sched
// Scoreboard bench for acc_group_sched. Stimulus tasks push the expected
// readout word addresses and expected per-group word totals into queues; a
// monitor process pops and compares whenever data_valid_o or group_done_o is
// seen. Directed scenarios plus a few randomised groups.
// -----------------------------------------------------------------------------
module tb_acc_group_sched;

    localparam int ADDR_W = 14;
    localparam int BIN_W  = 10;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [15:0]       pulse_num_i = '0;
    logic [4:0]        rangebin_num_i = '0;
    logic              spec_acc_done_i = 1'b0;
    logic              capture_en_o;
    logic              spec_acc_ctrl_o;
    logic [15:0]       pulse_counts_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              rd_sel_o;
    logic              data_valid_o;
    logic              group_done_o;
    logic              busy_o;

    acc_group_sched #(
        .ADDR_W (ADDR_W),
        .BIN_W  (BIN_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .pulse_num_i     (pulse_num_i),
        .rangebin_num_i  (rangebin_num_i),
        .spec_acc_done_i (spec_acc_done_i),
        .capture_en_o    (capture_en_o),
        .spec_acc_ctrl_o (spec_acc_ctrl_o),
        .pulse_counts_o  (pulse_counts_o),
        .rd_addr_o       (rd_addr_o),
        .rd_sel_o        (rd_sel_o),
        .data_valid_o    (data_valid_o),
        .group_done_o    (group_done_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    int word_q[$];   // expected address of each valid readout word, in order
    int done_q[$];   // expected word total for each completed group

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input longint act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d expected=none", name, act);
    endtask

    // Reference rules for the latched configuration.
    function automatic int eff_pulses(input int pn);
        return (pn == 0) ? 1 : pn;
    endfunction

    function automatic int eff_bins(input int rb);
        if (rb == 0) return 1;
        if (rb > 16) return 16;
        return rb;
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        logic             prev_sel;
        logic             prev_valid;
        logic [ADDR_W-1:0] prev_addr;
        int               words_since;
        int               exp;
        prev_sel    = 1'b0;
        prev_valid  = 1'b0;
        prev_addr   = '0;
        words_since = 0;
        forever begin
            @(negedge clk_i);
            if (rd_sel_o && !prev_sel) words_since = 0;
            if (data_valid_o) begin
                if (word_q.size() == 0) begin
                    fail_now("unexpected_word", int'(prev_addr));
                end else begin
                    exp = word_q.pop_front();
                    chk("word_addr", int'(prev_addr), exp);
                    if (!prev_sel) fail_now("word_without_rd_sel", int'(prev_addr));
                end
                words_since++;
            end
            if (group_done_o) begin
                if (done_q.size() == 0) begin
                    fail_now("unexpected_group_done", words_since);
                end else begin
                    exp = done_q.pop_front();
                    $display("group_done words=%0d expected=%0d", words_since, exp);
                    chk("group_words", words_since, exp);
                    chk("done_after_last_valid", {prev_valid, data_valid_o}, 2'b10);
                end
            end
            prev_sel   = rd_sel_o;
            prev_valid = data_valid_o;
            prev_addr  = rd_addr_o;
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic check_all_zero(input string tag);
        chk({tag, "_capture_en"}, capture_en_o, 0);
        chk({tag, "_ctrl"}, spec_acc_ctrl_o, 0);
        chk({tag, "_pulse_counts"}, pulse_counts_o, 0);
        chk({tag, "_rd_addr"}, rd_addr_o, 0);
        chk({tag, "_rd_sel"}, rd_sel_o, 0);
        chk({tag, "_data_valid"}, data_valid_o, 0);
        chk({tag, "_group_done"}, group_done_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic issue_start(input int pn, input int rb);
        start_i        = 1'b1;
        pulse_num_i    = 16'(pn);
        rangebin_num_i = 5'(rb);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Full group: start, pn pulses, drain, readout, done.
    task automatic run_group(input int pn, input int rb);
        int epn, erb, words, n, gap;
        bit seen;
        epn   = eff_pulses(pn);
        erb   = eff_bins(rb);
        words = erb << BIN_W;
        $display("group start pn=%0d rb=%0d -> pulses=%0d words=%0d", pn, rb, epn, words);
        for (int a = 0; a < words; a++) word_q.push_back(a);
        done_q.push_back(words);

        issue_start(pn, rb);
        chk("accum_busy", busy_o, 1);
        chk("accum_pulse_counts_clear", pulse_counts_o, 0);
        for (int p = 0; p < epn; p++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk_i);
            chk("accum_capture_en", capture_en_o, 1);
            chk("accum_ctrl", spec_acc_ctrl_o, (p != 0) ? 1 : 0);
            spec_acc_done_i = 1'b1;
            @(negedge clk_i);
            spec_acc_done_i = 1'b0;
            chk("pulse_counts", pulse_counts_o, p + 1);
            chk("capture_after_pulse", capture_en_o, (p + 1 < epn) ? 1 : 0);
        end

        n = 0;
        while (rd_sel_o == 1'b0 && n < 20) begin
            chk("drain_busy", busy_o, 1);
            n++;
            @(negedge clk_i);
        end
        chk("drain_cycles", n, 4);

        // Ignored start/spec_acc_done noise during readout.
        n = 0;
        seen = 1'b0;
        while (!seen && n < words + 20) begin
            if (group_done_o) begin
                seen = 1'b1;
            end else begin
                spec_acc_done_i = 1'($urandom_range(0, 1));
                start_i         = 1'($urandom_range(0, 1));
                @(negedge clk_i);
                n++;
            end
        end
        spec_acc_done_i = 1'b0;
        start_i         = 1'b0;
        chk("group_done_seen", seen, 1);
        @(negedge clk_i);
        chk("idle_after_done_busy", busy_o, 0);
        chk("single_done_pulse", group_done_o, 0);
        chk("counts_held_after_group", pulse_counts_o, epn);
    endtask

    // One-bin group cut short at readout address stop_addr by abort or reset.
    task automatic cut_readout(input bit use_rst, input int stop_addr);
        int n;
        $display("cut readout use_rst=%0d at addr=%0d", use_rst, stop_addr);
        for (int a = 0; a < stop_addr; a++) word_q.push_back(a);
        issue_start(1, 1);
        spec_acc_done_i = 1'b1;
        @(negedge clk_i);
        spec_acc_done_i = 1'b0;
        n = 0;
        while (!(rd_sel_o && int'(rd_addr_o) == stop_addr) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 2000) fail_now("wait_readout_addr_timeout", n);
        if (use_rst) rst_i = 1'b1;
        else         abort_i = 1'b1;
        @(negedge clk_i);
        rst_i   = 1'b0;
        abort_i = 1'b0;
        chk("cut_rd_sel", rd_sel_o, 0);
        chk("cut_data_valid", data_valid_o, 0);
        chk("cut_busy", busy_o, 0);
        chk("cut_capture_en", capture_en_o, 0);
        chk("cut_pulse_counts", pulse_counts_o, use_rst ? 0 : 1);
        if (use_rst) chk("cut_rd_addr", rd_addr_o, 0);
        repeat (6) begin
            @(negedge clk_i);
            chk("cut_no_group_done", group_done_o, 0);
        end
    endtask

    initial begin : stimulus
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("post_reset");

        // start and abort together in IDLE: abort wins
        start_i = 1'b1; abort_i = 1'b1; pulse_num_i = 16'd2; rangebin_num_i = 5'd1;
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        chk("start_abort_idle_busy", busy_o, 0);
        chk("start_abort_idle_capture", capture_en_o, 0);

        run_group(3, 2);
        run_group(0, 0);
        run_group(1, 20);

        cut_readout(1'b0, 500);
        run_group(2, 1);

        // spec_acc_done with abort at pulse_counts==1
        issue_start(3, 1);
        spec_acc_done_i = 1'b1;
        @(negedge clk_i);
        chk("done_abort_pre_count", pulse_counts_o, 1);
        abort_i = 1'b1;
        @(negedge clk_i);
        spec_acc_done_i = 1'b0;
        abort_i = 1'b0;
        chk("done_abort_busy", busy_o, 0);
        chk("done_abort_count", pulse_counts_o, 1);
        repeat (3) @(negedge clk_i);
        chk("done_abort_count_held", pulse_counts_o, 1);

        // reset mid-ACCUM with start high
        issue_start(4, 2);
        spec_acc_done_i = 1'b1;
        @(negedge clk_i);
        spec_acc_done_i = 1'b0;
        rst_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        check_all_zero("rst_mid_accum");
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("after_rst_mid_accum");

        cut_readout(1'b1, 300);

        for (int g = 0; g < 4; g++) begin
            run_group(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clk_i);
        chk("words_outstanding", word_q.size(), 0);
        chk("groups_outstanding", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_timeout actual=%0t expected=finish", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
